thegame_reset_seq: RTL

- **Function:** reset sequencer that consumes the game PLL's output clock and `locked` flag.
- **Output:** clean, staged, synchronous active-high resets for the core and peripheral domains, plus a `ready` flag.
- **Position:** directly downstream of the PLL wrapper; every other block in the 100 MHz domain takes its reset from here.
- **Fault handling:** debounces lock acquisition and re-enters reset on any loss of lock.

---
 rtl/thegame_reset_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/thegame_reset_seq.sv
// Staged reset sequencer for the 100 MHz game clock domain: qualifies PLL lock, then releases
// core and peripheral resets in order. Define THEGAME_RSTSEQ_LOCK_CNT_EN to build the lock-loss counter.
module thegame_reset_seq #(
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned RELEASE_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       ext_reset_req,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        StReset,
        StWaitLock,
        StStable,
        StHold,
        StRelease,
        StRun
    } state_e;

    localparam logic [15:0] LockLast = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GapLast  = 16'(RELEASE_GAP - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sync_meta_q, locked_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
            state_q     <= StReset;
            cnt_q       <= '0;
        end else begin
            sync_meta_q <= pll_locked;
            locked_s_q  <= sync_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    // Loss of lock is checked first in every active state so it beats ext_reset_req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReset: state_d = StWaitLock;
            StWaitLock: begin
                if (locked_s_q) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end
            end
            StStable: begin
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                end else if (cnt_q == LockLast) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StHold: begin
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRelease: begin
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                end else if (ext_reset_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (cnt_q == GapLast) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun: begin
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                end else if (ext_reset_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        rst_core   = 1'b1;
        rst_periph = 1'b1;
        ready      = 1'b0;
        unique case (state_q)
            StRelease: rst_core = 1'b0;
            StRun: begin
                rst_core   = 1'b0;
                rst_periph = 1'b0;
                ready      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef THEGAME_RSTSEQ_LOCK_CNT_EN
    logic [7:0] loss_q;
    logic       lock_fall;

    // locked_s drops on the next edge exactly when this is high.
    assign lock_fall = locked_s_q & ~sync_meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (lock_fall && (state_q != StReset) && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule
